// File: rtl/btb_update_sched_pkg.sv
// Shared types and constants for the BTB update scheduler.
// Latency: n/a (types, constants and one pure function).
// Backpressure: n/a.
package btb_update_sched_pkg;

   localparam int PC_W       = 8;
   localparam int BTB_N      = 8;
   localparam int IDX_W      = $clog2(BTB_N);
   localparam int Q_DEPTH    = 4;
   localparam int QP_W       = $clog2(Q_DEPTH);
   localparam int STARVE_MAX = 3;
   localparam int STARVE_W   = $clog2(STARVE_MAX + 1);

   // One pending BTB write.
   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [PC_W-1:0]  tag;
      logic [PC_W-1:0]  tgt;
      logic [1:0]       state;
   } btb_upd_t;

   // 2-bit saturating counter step: up on taken, down on not taken.
   function automatic logic [1:0] sat2(input logic [1:0] s, input logic taken);
      if (taken) return (s == 2'd3) ? s : s + 2'd1;
      else       return (s == 2'd0) ? s : s - 2'd1;
   endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Circular update queue with a tag search that returns the youngest matching entry.
// Latency: a push is visible at the head/compare outputs one cycle later.
// Backpressure: none internally; the caller pops whenever full so a push is never lost.
// Ports: i_push/i_push_dat write the tail, i_pop retires the head (o_head_dat),
//        o_count is occupancy, i_cmp_tag searches live entries -> o_cmp_hit/_idx/_state.
module btb_upd_fifo
   import btb_update_sched_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  btb_upd_t         i_push_dat,
   input  logic             i_pop,
   output btb_upd_t         o_head_dat,
   output logic [QP_W:0]    o_count,
   input  logic [PC_W-1:0]  i_cmp_tag,
   output logic             o_cmp_hit,
   output logic [IDX_W-1:0] o_cmp_idx,
   output logic [1:0]       o_cmp_state
);

   btb_upd_t        r_mem [Q_DEPTH];
   logic [QP_W-1:0] r_rd_ptr;
   logic [QP_W-1:0] r_wr_ptr;
   logic [QP_W:0]   r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
            r_wr_ptr        <= r_wr_ptr + QP_W'(1);
         end
         if (i_pop) r_rd_ptr <= r_rd_ptr + QP_W'(1);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + (QP_W+1)'(1);
            2'b01:   r_count <= r_count - (QP_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head_dat = r_mem[r_rd_ptr];
   assign o_count    = r_count;

   // Walk oldest -> youngest so the last match (youngest) overrides earlier ones.
   always_comb begin
      o_cmp_hit   = 1'b0;
      o_cmp_idx   = '0;
      o_cmp_state = '0;
      for (int i = 0; i < Q_DEPTH; i++) begin
         if (((QP_W+1)'(i) < r_count) &&
             (r_mem[r_rd_ptr + QP_W'(i)].tag == i_cmp_tag)) begin
            o_cmp_hit   = 1'b1;
            o_cmp_idx   = r_mem[r_rd_ptr + QP_W'(i)].idx;
            o_cmp_state = r_mem[r_rd_ptr + QP_W'(i)].state;
         end
      end
   end

endmodule

// File: rtl/btb_update_sched.sv
// Turns EX branch resolutions into a registered flush/redirect and queued BTB writes.
// Latency: flush 1 cycle after a mispredict; a BTB write is at least 1 cycle after resolution.
// Backpressure: fetch owns the BTB port unless the queue is full or updates starved STARVE_MAX cycles.
// Ports: i_res_* resolution from EX, i_fetch_req/o_fetch_stall port arbitration,
//        o_flush/o_redirect_pc front-end kill, o_btb_wr_* BTB write port, o_q_count occupancy.
module btb_update_sched
   import btb_update_sched_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_res_valid,
   input  logic [PC_W-1:0]  i_res_pc,
   input  logic [PC_W-1:0]  i_res_target,
   input  logic             i_res_taken,
   input  logic             i_res_pred,
   input  logic             i_res_hit,
   input  logic [IDX_W-1:0] i_res_idx,
   input  logic [1:0]       i_res_state,
   input  logic             i_fetch_req,
   output logic             o_fetch_stall,
   output logic             o_flush,
   output logic [PC_W-1:0]  o_redirect_pc,
   output logic             o_btb_wr_en,
   output logic [IDX_W-1:0] o_btb_wr_idx,
   output logic [PC_W-1:0]  o_btb_wr_tag,
   output logic [PC_W-1:0]  o_btb_wr_tgt,
   output logic [1:0]       o_btb_wr_state,
   output logic [QP_W:0]    o_q_count
);

   logic                r_flush;
   logic [PC_W-1:0]     r_redirect;
   logic [IDX_W-1:0]    r_alloc_ptr;
   logic [STARVE_W-1:0] r_starve;

   logic                w_mispred;
   logic                w_push;
   logic                w_pop;
   logic                w_nonempty;
   logic                w_full;
   logic                w_starved;
   logic                w_cmp_hit;
   logic [IDX_W-1:0]    w_cmp_idx;
   logic [1:0]          w_cmp_state;
   logic [1:0]          w_base;
   logic [QP_W:0]       w_count;
   btb_upd_t            w_push_dat;
   btb_upd_t            w_head;

   assign w_mispred = i_res_valid & (i_res_pred != i_res_taken);

   // A not-taken miss has nothing worth caching.
   assign w_push = i_res_valid & (i_res_hit | i_res_taken);

   // A still-queued write to the same PC is newer than what fetch read.
   assign w_base = w_cmp_hit ? w_cmp_state : i_res_state;

   always_comb begin
      w_push_dat     = '0;
      w_push_dat.tag = i_res_pc;
      w_push_dat.tgt = i_res_target;
      if (i_res_hit) begin
         w_push_dat.idx   = i_res_idx;
         w_push_dat.state = sat2(w_base, i_res_taken);
      end else if (w_cmp_hit) begin
         // Miss on a PC already allocated in the queue: keep its slot.
         w_push_dat.idx   = w_cmp_idx;
         w_push_dat.state = sat2(w_cmp_state, i_res_taken);
      end else begin
         w_push_dat.idx   = r_alloc_ptr;
         w_push_dat.state = 2'b10;
      end
   end

   assign w_nonempty = (w_count != '0);
   assign w_full     = (w_count == (QP_W+1)'(Q_DEPTH));
   assign w_starved  = (r_starve == STARVE_W'(STARVE_MAX));

   // Full always drains, which makes push-while-full a simultaneous pop+push.
   assign w_pop         = w_nonempty & (~i_fetch_req | w_starved | w_full);
   assign o_fetch_stall = w_pop & i_fetch_req;

   btb_upd_fifo u_fifo (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (w_push),
      .i_push_dat  (w_push_dat),
      .i_pop       (w_pop),
      .o_head_dat  (w_head),
      .o_count     (w_count),
      .i_cmp_tag   (i_res_pc),
      .o_cmp_hit   (w_cmp_hit),
      .o_cmp_idx   (w_cmp_idx),
      .o_cmp_state (w_cmp_state)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_flush     <= 1'b0;
         r_redirect  <= '0;
         r_alloc_ptr <= '0;
         r_starve    <= '0;
      end else begin
         r_flush    <= w_mispred;
         r_redirect <= !w_mispred   ? '0 :
                       i_res_taken  ? i_res_target : i_res_pc + PC_W'(1);
         if (w_push & ~i_res_hit & ~w_cmp_hit)
            r_alloc_ptr <= r_alloc_ptr + IDX_W'(1);
         if (w_pop)
            r_starve <= '0;
         else if (w_nonempty & i_fetch_req)
            r_starve <= r_starve + STARVE_W'(1);
      end
   end

   assign o_flush        = r_flush;
   assign o_redirect_pc  = r_redirect;
   assign o_btb_wr_en    = w_pop;
   assign o_btb_wr_idx   = w_pop ? w_head.idx   : '0;
   assign o_btb_wr_tag   = w_pop ? w_head.tag   : '0;
   assign o_btb_wr_tgt   = w_pop ? w_head.tgt   : '0;
   assign o_btb_wr_state = w_pop ? w_head.state : '0;
   assign o_q_count      = w_count;

endmodule

// File: tb/tb_btb_update_sched.sv
module tb_btb_update_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic       res_valid, res_taken, res_pred, res_hit, fetch_req;
   logic [7:0] res_pc, res_target;
   logic [2:0] res_idx;
   logic [1:0] res_state;
   logic       fetch_stall, flush, btb_wr_en;
   logic [7:0] redirect_pc, btb_wr_tag, btb_wr_tgt;
   logic [2:0] btb_wr_idx, q_count;
   logic [1:0] btb_wr_state;

   always #5 clk = ~clk;

   btb_update_sched dut (
      .i_clk(clk), .i_rst(rst),
      .i_res_valid(res_valid), .i_res_pc(res_pc), .i_res_target(res_target),
      .i_res_taken(res_taken), .i_res_pred(res_pred), .i_res_hit(res_hit),
      .i_res_idx(res_idx), .i_res_state(res_state), .i_fetch_req(fetch_req),
      .o_fetch_stall(fetch_stall), .o_flush(flush), .o_redirect_pc(redirect_pc),
      .o_btb_wr_en(btb_wr_en), .o_btb_wr_idx(btb_wr_idx), .o_btb_wr_tag(btb_wr_tag),
      .o_btb_wr_tgt(btb_wr_tgt), .o_btb_wr_state(btb_wr_state), .o_q_count(q_count)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
   endtask

   // Reference model: list of pending writes, oldest first.
   typedef struct {int idx; int tag; int tgt; int st;} ent_t;
   ent_t mq[$];
   int   m_alloc  = 0;
   int   m_starve = 0;
   int   m_flush  = 0;
   int   m_redir  = 0;
   int   m_wr     = 0;

   task automatic model_reset();
      mq.delete();
      m_alloc = 0; m_starve = 0; m_flush = 0; m_redir = 0;
   endtask

   // Apply inputs, then check all outputs mid-cycle against the model.
   task automatic drive(input int r, input int v, input int pc, input int tgt, input int tk,
                        input int pd, input int ht, input int ix, input int st, input int fr);
      int n;
      rst = r[0]; res_valid = v[0]; res_pc = 8'(pc); res_target = 8'(tgt);
      res_taken = tk[0]; res_pred = pd[0]; res_hit = ht[0]; res_idx = 3'(ix);
      res_state = 2'(st); fetch_req = fr[0];
      @(negedge clk);
      n    = mq.size();
      m_wr = (n > 0 && (fr == 0 || m_starve == 3 || n == 4)) ? 1 : 0;
      if (r == 0) begin
         chk("q_count", int'(q_count), n);
         chk("wr_en", int'(btb_wr_en), m_wr);
         chk("fetch_stall", int'(fetch_stall), (m_wr == 1 && fr == 1) ? 1 : 0);
         chk("flush", int'(flush), m_flush);
         if (m_flush == 1) chk("redirect", int'(redirect_pc), m_redir);
         if (m_wr == 1) begin
            chk("wr_idx", int'(btb_wr_idx), mq[0].idx);
            chk("wr_tag", int'(btb_wr_tag), mq[0].tag);
            chk("wr_tgt", int'(btb_wr_tgt), mq[0].tgt);
            chk("wr_state", int'(btb_wr_state), mq[0].st);
         end
      end
   endtask

   // Advance the model across the clock edge, then move to just after it.
   task automatic tick();
      int   fi, base, ns, n, pc, tk;
      ent_t e;
      if (rst) model_reset();
      else begin
         n  = mq.size();
         pc = int'(res_pc);
         tk = int'(res_taken);
         fi = -1;
         for (int i = 0; i < n; i++) if (mq[i].tag == pc) fi = i;
         if (res_valid && (res_hit || res_taken)) begin
            base = (fi >= 0) ? mq[fi].st : int'(res_state);
            ns   = tk ? ((base + 1 > 3) ? 3 : base + 1) : ((base - 1 < 0) ? 0 : base - 1);
            e.tag = pc; e.tgt = int'(res_target);
            if (res_hit) begin
               e.idx = int'(res_idx); e.st = ns;
            end else if (fi >= 0) begin
               e.idx = mq[fi].idx; e.st = ns;
            end else begin
               e.idx = m_alloc; e.st = 2; m_alloc = (m_alloc + 1) % 8;
            end
         end
         if (m_wr == 1) m_starve = 0;
         else if (n > 0 && fetch_req) m_starve++;
         if (m_wr == 1) void'(mq.pop_front());
         if (res_valid && (res_hit || res_taken)) mq.push_back(e);
         m_flush = (res_valid && (res_pred != res_taken)) ? 1 : 0;
         m_redir = res_taken ? int'(res_target) : (pc + 1) % 256;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int fr);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, fr);
   endtask

   initial begin
      @(posedge clk);
      #1;
      // Reset held while a mispredict is presented.
      repeat (3) begin drive(1, 1, 'h10, 'h40, 1, 0, 0, 0, 0, 1); tick(); end

      idle(0);
      chk("rst_flush", int'(flush), 0);
      chk("rst_wr_en", int'(btb_wr_en), 0);
      chk("rst_q_count", int'(q_count), 0);
      tick();

      // Miss, taken: allocate idx 0, redirect to target.
      drive(0, 1, 'h10, 'h40, 1, 0, 0, 0, 0, 0); tick();
      idle(0);
      chk("t2_flush", int'(flush), 1);
      chk("t2_redirect", int'(redirect_pc), 'h40);
      chk("t2_wr_en", int'(btb_wr_en), 1);
      chk("t2_wr_idx", int'(btb_wr_idx), 0);
      chk("t2_wr_state", int'(btb_wr_state), 2);
      tick();

      // Hit, strongly taken but resolved not taken at PC 0xFF: redirect wraps.
      drive(0, 1, 'hFF, 'h80, 0, 1, 1, 2, 3, 0); tick();
      idle(0);
      chk("t3_flush", int'(flush), 1);
      chk("t3_redirect", int'(redirect_pc), 0);
      chk("t3_wr_idx", int'(btb_wr_idx), 2);
      chk("t3_wr_state", int'(btb_wr_state), 2);
      tick();

      // Starvation: fetch holds the port; the update steals it on the 4th cycle.
      drive(0, 1, 'h30, 'h50, 1, 1, 1, 5, 1, 1); tick();
      for (int k = 0; k < 3; k++) begin
         idle(1); chk("t4_blocked", int'(btb_wr_en), 0); tick();
      end
      idle(1);
      chk("t4_stall", int'(fetch_stall), 1);
      chk("t4_wr_en", int'(btb_wr_en), 1);
      tick();
      idle(1); chk("t4_empty", int'(q_count), 0); tick();

      // Fill to full, then push while full.
      for (int k = 0; k < 4; k++) begin
         drive(0, 1, 'h60 + k, 'h11, 1, 1, 1, k, 1, 1); tick();
      end
      drive(0, 1, 'h70, 'h22, 1, 1, 1, 6, 1, 1);
      chk("t5_q_full", int'(q_count), 4);
      chk("t5_stall", int'(fetch_stall), 1);
      tick();
      idle(1); chk("t5_q_kept", int'(q_count), 4); tick();
      repeat (6) begin idle(0); tick(); end

      // Two queued hits on one PC: second counter forwards from the first.
      repeat (2) begin drive(0, 1, 'h90, 'h33, 1, 1, 1, 3, 1, 1); tick(); end
      idle(0); chk("t6_fwd_a", int'(btb_wr_state), 2); tick();
      idle(0); chk("t6_fwd_b", int'(btb_wr_state), 3); tick();

      // Nine allocations after reset: the ninth reuses idx 0.
      repeat (2) begin drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick(); end
      for (int k = 0; k < 9; k++) begin
         drive(0, 1, 'hA0 + k, k, 1, 1, 0, 0, 0, 0); tick();
      end
      idle(0); chk("t6_wrap_idx", int'(btb_wr_idx), 0); tick();

      // Random traffic on a small PC set so forwarding and allocation reuse occur.
      for (int c = 0; c < 1500; c++) begin
         drive(($urandom_range(0, 149) == 0) ? 1 : 0,
               ($urandom_range(0, 99) < 60) ? 1 : 0,
               'h20 + int'($urandom_range(0, 5)),
               int'($urandom_range(0, 255)),
               int'($urandom_range(0, 1)),
               int'($urandom_range(0, 1)),
               int'($urandom_range(0, 1)),
               int'($urandom_range(0, 7)),
               int'($urandom_range(0, 3)),
               ($urandom_range(0, 99) < 70) ? 1 : 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
